// File: rtl/kronos_types.sv
`default_nettype none
// ============================================================================
// Module   : kronos_types
// Brief    : Shared types and constants for the Kronos control-flow logic.
// Revision : 1.0 - initial release
// ============================================================================
package kronos_types;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    TRAP     = 2'd2
  } redirect_state_e;

  // Low target bits that must be zero for a 32-bit aligned instruction fetch
  localparam logic [1:0] IALIGN_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/kronos_redirect.sv
`default_nettype none
// ============================================================================
// Module   : kronos_redirect
// Brief    : Accepts resolved branch/jump outcomes and issues a fetch redirect
//            or a misaligned-target trap, squashing younger instructions.
// Revision : 1.0 - initial release
// ============================================================================
module kronos_redirect
  import kronos_types::*;
#(
  parameter int CATCH_MISALIGNED = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             ex_vld,
  output logic             ex_rdy,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [31:0]      ex_target,
  output logic             fe_vld,
  input  logic             fe_rdy,
  output logic [31:0]      fe_pc,
  output logic             flush,
  output logic             trap_vld,
  input  logic             trap_rdy,
  output logic [31:0]      trap_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  redirect_state_e  r_state;
  logic             r_fe_vld;
  logic             r_trap_vld;
  logic             r_flush;
  logic [31:0]      r_fe_pc;
  logic [31:0]      r_trap_addr;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_taken;
  logic w_misaligned;

  assign w_taken      = ex_branch | ex_jump;
  assign w_misaligned = (CATCH_MISALIGNED != 0) &&
                        ((ex_target[1:0] & IALIGN_MASK) != 2'b00);

  // Ready depends on state only, so execute never sees a path from fetch/trap ready
  assign ex_rdy    = (r_state == IDLE);
  assign fe_vld    = r_fe_vld;
  assign trap_vld  = r_trap_vld;
  assign flush     = r_flush;
  assign fe_pc     = r_fe_pc;
  assign trap_addr = r_trap_addr;
  assign taken_cnt = r_taken_cnt;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state     <= IDLE;
      r_fe_vld    <= 1'b0;
      r_trap_vld  <= 1'b0;
      r_flush     <= 1'b0;
      r_fe_pc     <= '0;
      r_trap_addr <= '0;
      r_taken_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_vld && w_taken) begin
            r_flush <= 1'b1;
            if (w_misaligned) begin
              r_state     <= TRAP;
              r_trap_vld  <= 1'b1;
              r_trap_addr <= ex_target;
            end else begin
              r_state     <= REDIRECT;
              r_fe_vld    <= 1'b1;
              r_fe_pc     <= ex_target;
              r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
          end
        end
        REDIRECT: begin
          if (fe_rdy) begin
            r_state  <= IDLE;
            r_fe_vld <= 1'b0;
            r_flush  <= 1'b0;
          end
        end
        TRAP: begin
          if (trap_rdy) begin
            r_state    <= IDLE;
            r_trap_vld <= 1'b0;
            r_flush    <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_fe_vld   <= 1'b0;
          r_trap_vld <= 1'b0;
          r_flush    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
